axis_deparser_arb: RTL and testbench
====================================

AXIS_DEPARSER_ARB -- requirements
Module: axis_deparser_arb

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requester port pairs (header stream plus payload stream), range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 512: payload tdata width; KEEP_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter HDR_DATA_WIDTH, default 560: header tdata width; HDR_KEEP_WIDTH = HDR_DATA_WIDTH/8.
REQ-004 SHALL have parameters ID_WIDTH=8, DEST_WIDTH=4, USER_WIDTH=4, shared by header and payload streams.
REQ-005 SHALL have clk, input, 1: clock; all logic is on the rising edge.
REQ-006 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have s_axis_hdr_{tdata,tkeep,tvalid,tready,tlast,tid,tdest,tuser}, with widths PORTS x the per-port field width, concatenated with port 0 in the LSBs; tready is an output and all other signals are inputs.
REQ-008 SHALL have s_axis_{tdata,tkeep,tvalid,tready,tlast,tid,tdest,tuser}, with widths PORTS x the per-port field width, packed the same way as the header bundle.
REQ-009 SHALL have m_axis_hdr_* as a single header stream to the deparser, with m_axis_hdr_tready as an input.
REQ-010 SHALL have m_axis_* as a single payload stream to the deparser, with m_axis_tready as an input.
REQ-011 SHALL have grant_port, output, $clog2(PORTS): index of the current owner; it is valid only while grant_active=1.
REQ-012 SHALL have grant_active, output, 1: high in states HDR and PAY.

Function
REQ-013 SHALL implement the state machine IDLE -> HDR -> PAY -> IDLE.
REQ-014 SHALL, in IDLE, treat port i as requesting when s_axis_hdr_tvalid[i]=1.
REQ-015 SHALL select the requesting port by round-robin, searching upward from (last_grant+1) mod PORTS and wrapping.
REQ-016 SHALL register the selected port and enter HDR on the next edge; arbitration costs exactly one idle cycle.
REQ-017 SHALL, in IDLE, drive all s tready=0, m_axis_hdr_tvalid=0 and m_axis_tvalid=0.
REQ-018 SHALL, in HDR, connect the granted header stream combinationally to m_axis_hdr_*, with tready passed back to the granted port only.
REQ-019 SHALL, in HDR, go to PAY on the header handshake (valid and ready).
REQ-020 SHALL forward exactly one header beat per grant; the header tlast value is passed through and otherwise ignored.
REQ-021 SHALL, in PAY, connect the granted payload stream combinationally to m_axis_*.
REQ-022 SHALL, in PAY, go to IDLE on a payload handshake with tlast=1, and set last_grant to the granted port on that edge.
REQ-023 SHALL keep tready=0 toward non-granted ports at all times; their data SHALL NOT reach the outputs.
REQ-024 SHALL keep the grant while the owner deasserts tvalid mid-packet; there is no preemption.
REQ-025 SHALL, when two or more ports request in the same IDLE cycle, grant only the first in round-robin order; the others keep tvalid asserted and are served in later grants.
REQ-026 SHALL add zero cycles of latency for forwarded beats; throughput in PAY is one beat per cycle.
REQ-027 SHALL, when the granted port deasserts s_axis_hdr_tvalid in HDR, remain in HDR (no timeout).

Reset
REQ-028 SHALL, on rst=1, set state=IDLE, last_grant=PORTS-1 (so port 0 wins first), grant_port=0 and grant_active=0.
REQ-029 SHALL drive all valid and ready outputs to 0 during reset and in the first cycle after it.
REQ-030 SHALL, on reset mid-packet, abandon the packet with no flush; downstream recovery is the deparser's own reset.

Configuration
REQ-031 SHALL, when macro AXIS_DEPARSER_ARB_TID_TAG_EN is defined, drive m_axis_hdr_tid and m_axis_tid with grant_port zero-extended to ID_WIDTH instead of the source tid.
REQ-032 SHALL, with AXIS_DEPARSER_ARB_TID_TAG_EN defined, stop elaboration with an error if ID_WIDTH < $clog2(PORTS).
REQ-033 SHALL, when AXIS_DEPARSER_ARB_TID_TAG_EN is undefined, pass tid through unchanged.

Verification
REQ-034 SHALL cover single requester: port 2 sends a header plus 3 payload beats, tlast on beat 3 -> grant_port=2; output shows 1 header and 3 beats with matching data; IDLE after tlast.
REQ-035 SHALL cover all 4 ports requesting continuously after reset -> grants in order 0,1,2,3,0.
REQ-036 SHALL cover backpressure: m_axis_tready=0 for 5 cycles mid-packet -> beat held stable, no loss or duplication, grant unchanged.
REQ-037 SHALL cover owner stall: port 1 tvalid low for 4 cycles mid-packet while port 3 requests -> port 3 tready stays 0 until port 1's tlast handshake, then port 3 is granted after one IDLE cycle.
REQ-038 SHALL cover reset in PAY: rst pulsed during beat 2 of port 0 -> next cycle all tready and tvalid are 0, state=IDLE, and port 0 wins the next arbitration.
REQ-039 SHALL cover tid tagging with AXIS_DEPARSER_ARB_TID_TAG_EN defined: port 3 sends source tid 0x55 -> output tid=0x03 on both streams; with the macro undefined -> output tid=0x55.

Source files
------------

// File: rtl/axis_deparser_arb.sv
// Round-robin arbiter that hands one header beat plus one payload packet per grant to the deparser.
// Optional AXIS_DEPARSER_ARB_TID_TAG_EN: replace the output tid with the granted port index.
module axis_deparser_arb #(
   parameter int PORTS          = 4,
   parameter int DATA_WIDTH     = 512,
   parameter int HDR_DATA_WIDTH = 560,
   parameter int ID_WIDTH       = 8,
   parameter int DEST_WIDTH     = 4,
   parameter int USER_WIDTH     = 4,
   localparam int KEEP_WIDTH     = DATA_WIDTH / 8,
   localparam int HDR_KEEP_WIDTH = HDR_DATA_WIDTH / 8,
   localparam int GRANT_WIDTH    = $clog2(PORTS)
) (
   input  logic                               clk,
   input  logic                               rst,

   input  logic [PORTS*HDR_DATA_WIDTH-1:0]    s_axis_hdr_tdata,
   input  logic [PORTS*HDR_KEEP_WIDTH-1:0]    s_axis_hdr_tkeep,
   input  logic [PORTS-1:0]                   s_axis_hdr_tvalid,
   output logic [PORTS-1:0]                   s_axis_hdr_tready,
   input  logic [PORTS-1:0]                   s_axis_hdr_tlast,
   input  logic [PORTS*ID_WIDTH-1:0]          s_axis_hdr_tid,
   input  logic [PORTS*DEST_WIDTH-1:0]        s_axis_hdr_tdest,
   input  logic [PORTS*USER_WIDTH-1:0]        s_axis_hdr_tuser,

   input  logic [PORTS*DATA_WIDTH-1:0]        s_axis_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0]        s_axis_tkeep,
   input  logic [PORTS-1:0]                   s_axis_tvalid,
   output logic [PORTS-1:0]                   s_axis_tready,
   input  logic [PORTS-1:0]                   s_axis_tlast,
   input  logic [PORTS*ID_WIDTH-1:0]          s_axis_tid,
   input  logic [PORTS*DEST_WIDTH-1:0]        s_axis_tdest,
   input  logic [PORTS*USER_WIDTH-1:0]        s_axis_tuser,

   output logic [HDR_DATA_WIDTH-1:0]          m_axis_hdr_tdata,
   output logic [HDR_KEEP_WIDTH-1:0]          m_axis_hdr_tkeep,
   output logic                               m_axis_hdr_tvalid,
   input  logic                               m_axis_hdr_tready,
   output logic                               m_axis_hdr_tlast,
   output logic [ID_WIDTH-1:0]                m_axis_hdr_tid,
   output logic [DEST_WIDTH-1:0]              m_axis_hdr_tdest,
   output logic [USER_WIDTH-1:0]              m_axis_hdr_tuser,

   output logic [DATA_WIDTH-1:0]              m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic                               m_axis_tlast,
   output logic [ID_WIDTH-1:0]                m_axis_tid,
   output logic [DEST_WIDTH-1:0]              m_axis_tdest,
   output logic [USER_WIDTH-1:0]              m_axis_tuser,

   output logic [GRANT_WIDTH-1:0]             grant_port,
   output logic                               grant_active
);

`ifdef AXIS_DEPARSER_ARB_TID_TAG_EN
   if (ID_WIDTH < GRANT_WIDTH) begin : g_tid_width_chk
      $error("axis_deparser_arb: ID_WIDTH too narrow to carry the grant index");
   end
`endif

   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   state_t                 state, state_n;
   logic [GRANT_WIDTH-1:0] last_grant, last_grant_n, grant_n;
   logic [GRANT_WIDTH-1:0] req_port;
   logic                   req_found;
   logic                   hdr_phase, pay_phase;
   int unsigned            sel, last_idx, cand;

   assign sel          = 32'(grant_port);
   assign last_idx     = 32'(last_grant);
   // Outputs are forced quiet while rst is high, even before the state register clears.
   assign hdr_phase    = (state == HDR) && !rst;
   assign pay_phase    = (state == PAY) && !rst;
   assign grant_active = hdr_phase || pay_phase;

   // Round-robin search starting just after the last completed owner.
   always_comb begin
      req_found = 1'b0;
      req_port  = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= PORTS; k++) begin
         cand = (last_idx + k) % PORTS;
         if (!req_found && s_axis_hdr_tvalid[cand]) begin
            req_found = 1'b1;
            req_port  = GRANT_WIDTH'(cand);
         end
      end
   end

   always_comb begin
      state_n      = state;
      grant_n      = grant_port;
      last_grant_n = last_grant;
      unique case (state)
         IDLE: if (req_found) begin
            state_n = HDR;
            grant_n = req_port;
         end
         HDR: if (m_axis_hdr_tvalid && m_axis_hdr_tready) state_n = PAY;
         PAY: if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state_n      = IDLE;
            last_grant_n = grant_port;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_port <= '0;
         last_grant <= GRANT_WIDTH'(PORTS - 1);
      end else begin
         state      <= state_n;
         grant_port <= grant_n;
         last_grant <= last_grant_n;
      end
   end

   always_comb begin
      s_axis_hdr_tready = '0;
      s_axis_tready     = '0;
      if (hdr_phase) s_axis_hdr_tready[grant_port] = m_axis_hdr_tready;
      if (pay_phase) s_axis_tready[grant_port]     = m_axis_tready;

      m_axis_hdr_tvalid = hdr_phase && s_axis_hdr_tvalid[grant_port];
      m_axis_hdr_tdata  = s_axis_hdr_tdata[sel*HDR_DATA_WIDTH +: HDR_DATA_WIDTH];
      m_axis_hdr_tkeep  = s_axis_hdr_tkeep[sel*HDR_KEEP_WIDTH +: HDR_KEEP_WIDTH];
      m_axis_hdr_tlast  = s_axis_hdr_tlast[grant_port];
      m_axis_hdr_tdest  = s_axis_hdr_tdest[sel*DEST_WIDTH +: DEST_WIDTH];
      m_axis_hdr_tuser  = s_axis_hdr_tuser[sel*USER_WIDTH +: USER_WIDTH];

      m_axis_tvalid     = pay_phase && s_axis_tvalid[grant_port];
      m_axis_tdata      = s_axis_tdata[sel*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep      = s_axis_tkeep[sel*KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tlast      = s_axis_tlast[grant_port];
      m_axis_tdest      = s_axis_tdest[sel*DEST_WIDTH +: DEST_WIDTH];
      m_axis_tuser      = s_axis_tuser[sel*USER_WIDTH +: USER_WIDTH];

`ifdef AXIS_DEPARSER_ARB_TID_TAG_EN
      m_axis_hdr_tid    = ID_WIDTH'(grant_port);
      m_axis_tid        = ID_WIDTH'(grant_port);
`else
      m_axis_hdr_tid    = s_axis_hdr_tid[sel*ID_WIDTH +: ID_WIDTH];
      m_axis_tid        = s_axis_tid[sel*ID_WIDTH +: ID_WIDTH];
`endif
   end

endmodule

// File: tb/tb_axis_deparser_arb.sv
// Randomized bench for axis_deparser_arb against a packet-level ownership model with per-port source queues.
module tb_axis_deparser_arb;
   localparam int P   = 4;
   localparam int DW  = 32;
   localparam int KW  = DW / 8;
   localparam int HW  = 48;
   localparam int HKW = HW / 8;
   localparam int IW  = 8;
   localparam int DSW = 4;
   localparam int UW  = 4;
   localparam int GW  = 2;
`ifdef AXIS_DEPARSER_ARB_TID_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [P*HW-1:0]  s_axis_hdr_tdata;
   logic [P*HKW-1:0] s_axis_hdr_tkeep;
   logic [P-1:0]     s_axis_hdr_tvalid, s_axis_hdr_tready, s_axis_hdr_tlast;
   logic [P*IW-1:0]  s_axis_hdr_tid;
   logic [P*DSW-1:0] s_axis_hdr_tdest;
   logic [P*UW-1:0]  s_axis_hdr_tuser;
   logic [P*DW-1:0]  s_axis_tdata;
   logic [P*KW-1:0]  s_axis_tkeep;
   logic [P-1:0]     s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [P*IW-1:0]  s_axis_tid;
   logic [P*DSW-1:0] s_axis_tdest;
   logic [P*UW-1:0]  s_axis_tuser;
   logic [HW-1:0]    m_axis_hdr_tdata;
   logic [HKW-1:0]   m_axis_hdr_tkeep;
   logic             m_axis_hdr_tvalid, m_axis_hdr_tready = 1'b0, m_axis_hdr_tlast;
   logic [IW-1:0]    m_axis_hdr_tid;
   logic [DSW-1:0]   m_axis_hdr_tdest;
   logic [UW-1:0]    m_axis_hdr_tuser;
   logic [DW-1:0]    m_axis_tdata;
   logic [KW-1:0]    m_axis_tkeep;
   logic             m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
   logic [IW-1:0]    m_axis_tid;
   logic [DSW-1:0]   m_axis_tdest;
   logic [UW-1:0]    m_axis_tuser;
   logic [GW-1:0]    grant_port;
   logic             grant_active;

   axis_deparser_arb #(
      .PORTS(P), .DATA_WIDTH(DW), .HDR_DATA_WIDTH(HW),
      .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_hdr_tdata(s_axis_hdr_tdata), .s_axis_hdr_tkeep(s_axis_hdr_tkeep),
      .s_axis_hdr_tvalid(s_axis_hdr_tvalid), .s_axis_hdr_tready(s_axis_hdr_tready),
      .s_axis_hdr_tlast(s_axis_hdr_tlast), .s_axis_hdr_tid(s_axis_hdr_tid),
      .s_axis_hdr_tdest(s_axis_hdr_tdest), .s_axis_hdr_tuser(s_axis_hdr_tuser),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
      .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
      .m_axis_hdr_tdata(m_axis_hdr_tdata), .m_axis_hdr_tkeep(m_axis_hdr_tkeep),
      .m_axis_hdr_tvalid(m_axis_hdr_tvalid), .m_axis_hdr_tready(m_axis_hdr_tready),
      .m_axis_hdr_tlast(m_axis_hdr_tlast), .m_axis_hdr_tid(m_axis_hdr_tid),
      .m_axis_hdr_tdest(m_axis_hdr_tdest), .m_axis_hdr_tuser(m_axis_hdr_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
      .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
      .grant_port(grant_port), .grant_active(grant_active)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [7:0]  id;
      logic [3:0]  dest;
      logic [3:0]  user;
   } beat_t;

   // Source queues and the model's view of who owns the output.
   beat_t       hdr_q[P][$];
   beat_t       pay_q[P][$];
   logic [P-1:0] hv = '0, pv = '0;
   int          stall[P];
   int          owner = -1, last_g = P - 1;
   logic        hdr_done = 1'b0;
   logic        rst_req = 1'b1;
   logic        prev_active = 1'b0;
   int          vprob = 100, rprob = 100, bp = 0;
   int          grants[$];
   int          n_cmp = 0, n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_tid(input logic [7:0] src, input int o);
      return TAG_EN ? 8'(o) : src;
   endfunction

   task automatic add_packet(input int p, input int nb, input logic [7:0] id);
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = 8'($urandom);
      b.last = 1'($urandom);
      b.id   = id;
      b.dest = 4'($urandom);
      b.user = 4'($urandom);
      hdr_q[p].push_back(b);
      for (int i = 0; i < nb; i++) begin
         b.data = {$urandom, $urandom};
         b.keep = 8'($urandom);
         b.dest = 4'($urandom);
         b.user = 4'($urandom);
         b.last = (i == nb - 1);
         pay_q[p].push_back(b);
      end
   endtask

   task automatic drive();
      beat_t h, d;
      rst = rst_req;
      for (int p = 0; p < P; p++) begin
         if (!hv[p] && hdr_q[p].size() > 0 && $urandom_range(99) < vprob) hv[p] = 1'b1;
         if (!pv[p] && pay_q[p].size() > 0 && stall[p] == 0 && $urandom_range(99) < vprob) pv[p] = 1'b1;
         if (stall[p] > 0) stall[p]--;
         h = hv[p] ? hdr_q[p][0] : '0;
         d = pv[p] ? pay_q[p][0] : '0;
         s_axis_hdr_tvalid[p]          = hv[p];
         s_axis_hdr_tdata[p*HW +: HW]  = h.data[HW-1:0];
         s_axis_hdr_tkeep[p*HKW +: HKW] = h.keep[HKW-1:0];
         s_axis_hdr_tlast[p]           = h.last;
         s_axis_hdr_tid[p*IW +: IW]    = h.id;
         s_axis_hdr_tdest[p*DSW +: DSW] = h.dest;
         s_axis_hdr_tuser[p*UW +: UW]  = h.user;
         s_axis_tvalid[p]              = pv[p];
         s_axis_tdata[p*DW +: DW]      = d.data[DW-1:0];
         s_axis_tkeep[p*KW +: KW]      = d.keep[KW-1:0];
         s_axis_tlast[p]               = d.last;
         s_axis_tid[p*IW +: IW]        = d.id;
         s_axis_tdest[p*DSW +: DSW]    = d.dest;
         s_axis_tuser[p*UW +: UW]      = d.user;
      end
      m_axis_hdr_tready = ($urandom_range(99) < rprob);
      m_axis_tready     = (bp == 0) && ($urandom_range(99) < rprob);
      if (bp > 0) bp--;
   endtask

   // One clock: drive after the falling edge, check before the rising edge, then advance the model.
   task automatic step();
      beat_t e;
      logic [P-1:0] eh, ep;
      logic evh, evp, act;
      int c;
      @(negedge clk);
      drive();
      #1;
      act = !rst && owner >= 0;
      evh = act && !hdr_done && hv[owner];
      evp = act && hdr_done && pv[owner];
      eh = '0;
      ep = '0;
      if (act && !hdr_done) eh[owner] = m_axis_hdr_tready;
      if (act && hdr_done)  ep[owner] = m_axis_tready;
      check("grant_active", 64'(grant_active), 64'(act));
      if (act) check("grant_port", 64'(grant_port), 64'(owner));
      check("m_hdr_tvalid", 64'(m_axis_hdr_tvalid), 64'(evh));
      check("m_tvalid", 64'(m_axis_tvalid), 64'(evp));
      check("s_hdr_tready", 64'(s_axis_hdr_tready), 64'(eh));
      check("s_tready", 64'(s_axis_tready), 64'(ep));
      if (evh) begin
         e = hdr_q[owner][0];
         check("hdr_tdata", 64'(m_axis_hdr_tdata), 64'(e.data[HW-1:0]));
         check("hdr_tkeep", 64'(m_axis_hdr_tkeep), 64'(e.keep[HKW-1:0]));
         check("hdr_tlast", 64'(m_axis_hdr_tlast), 64'(e.last));
         check("hdr_tid", 64'(m_axis_hdr_tid), 64'(exp_tid(e.id, owner)));
         check("hdr_tdest", 64'(m_axis_hdr_tdest), 64'(e.dest));
         check("hdr_tuser", 64'(m_axis_hdr_tuser), 64'(e.user));
      end
      if (evp) begin
         e = pay_q[owner][0];
         check("pay_tdata", 64'(m_axis_tdata), 64'(e.data[DW-1:0]));
         check("pay_tkeep", 64'(m_axis_tkeep), 64'(e.keep[KW-1:0]));
         check("pay_tlast", 64'(m_axis_tlast), 64'(e.last));
         check("pay_tid", 64'(m_axis_tid), 64'(exp_tid(e.id, owner)));
         check("pay_tdest", 64'(m_axis_tdest), 64'(e.dest));
         check("pay_tuser", 64'(m_axis_tuser), 64'(e.user));
      end
      if (grant_active && !prev_active) grants.push_back(int'(grant_port));
      prev_active = grant_active;

      if (rst) begin
         owner = -1; last_g = P - 1; hdr_done = 1'b0; hv = '0; pv = '0;
         for (int p = 0; p < P; p++) begin
            hdr_q[p].delete();
            pay_q[p].delete();
         end
      end else if (owner < 0) begin
         for (int k = 1; k <= P; k++) begin
            c = (last_g + k) % P;
            if (owner < 0 && hv[c]) begin
               owner = c;
               hdr_done = 1'b0;
            end
         end
      end else if (!hdr_done) begin
         if (evh && m_axis_hdr_tready) begin
            void'(hdr_q[owner].pop_front());
            hv[owner] = 1'b0;
            hdr_done = 1'b1;
         end
      end else if (evp && m_axis_tready) begin
         e = pay_q[owner].pop_front();
         pv[owner] = 1'b0;
         if (e.last) begin
            last_g = owner;
            owner = -1;
         end
      end
   endtask

   function automatic logic all_idle();
      logic r = (owner < 0) && (hv == '0) && (pv == '0);
      for (int p = 0; p < P; p++)
         if (hdr_q[p].size() != 0 || pay_q[p].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (!all_idle() && n < budget) begin
         step();
         n++;
      end
      check(tag, 64'(all_idle()), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int p = 0; p < P; p++) stall[p] = 0;
      rst_req = 1'b1;
      repeat (3) step();
      rst_req = 1'b0;
      step();

      // All ports requesting back-to-back: grants must rotate starting at port 0.
      grants.delete();
      vprob = 100; rprob = 100;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < P; p++) add_packet(p, 1 + $urandom_range(2), 8'($urandom));
      drain("rr_drain", 200);
      check("rr_count_ok", 64'(grants.size() >= 5), 64'd1);
      for (int i = 0; i < 5; i++)
         if (i < grants.size()) check("rr_order", 64'(grants[i]), 64'(i % P));

      // Single requester on port 2 with a 5-cycle downstream stall after the first beat.
      add_packet(2, 3, 8'h21);
      n = 0;
      while (!(owner == 2 && hdr_done && pay_q[2].size() == 2) && n < 50) begin step(); n++; end
      check("bp_reached", 64'(n < 50), 64'd1);
      bp = 5;
      drain("single_drain", 100);
      check("single_last_grant", 64'(grants[grants.size()-1]), 64'd2);

      // Owner stalls mid-packet while port 3 waits.
      add_packet(1, 3, 8'h11);
      n = 0;
      while (pay_q[1].size() != 2 && n < 50) begin step(); n++; end
      check("stall_reached", 64'(n < 50), 64'd1);
      stall[1] = 4;
      add_packet(3, 2, 8'h33);
      drain("stall_drain", 100);
      check("stall_then_p3", 64'(grants[grants.size()-1]), 64'd3);

      // Heavy random traffic with random gaps and backpressure.
      vprob = 60; rprob = 60;
      for (int r = 0; r < 6; r++)
         for (int p = 0; p < P; p++) add_packet(p, 1 + $urandom_range(3), 8'($urandom));
      drain("rand_drain", 4000);

      // Reset while port 0 is on its second payload beat; port 0 must win again afterwards.
      vprob = 100; rprob = 100;
      add_packet(0, 4, 8'h01);
      n = 0;
      while (pay_q[0].size() != 3 && n < 50) begin step(); n++; end
      check("rst_reached", 64'(n < 50), 64'd1);
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      step();
      add_packet(2, 2, 8'h02);
      add_packet(0, 2, 8'h03);
      drain("post_rst_drain", 100);
      check("post_rst_first", 64'(grants[grants.size()-2]), 64'd0);

      // Port 3 with source tid 0x55.
      add_packet(3, 2, 8'h55);
      drain("tid_drain", 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
